ico_sweep: RTL and testbench

- Programmable frequency-sweep controller that generates the 15-bit `increment` word for the increment-controlled oscillator.
- Steps the oscillator frequency from a start word to a stop word in fixed increments, holding each value for a programmable dwell time. Each word w gives an oscillator frequency of w·40e6/2^24 Hz.
- Supports single sweeps and continuous triangle sweeps between the two endpoints.
- Sits directly upstream of the oscillator. Its `increment` output drives the oscillator's increment input on the same 40 MHz clock.

---
 rtl/ico_sweep.sv | 131 +++++++++++++
 tb/tb_ico_sweep.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ico_sweep.sv
// ico_sweep: frequency-sweep controller driving the increment word of the ICO.
// Runs single or continuous triangle sweeps between two latched endpoints with a fixed dwell.
module ico_sweep #(
   parameter int unsigned DWELL_W = 24
) (
   input  logic               clk40MHz,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [14:0]        f_start,
   input  logic [14:0]        f_stop,
   input  logic [14:0]        f_step,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               mode,
   output logic [14:0]        increment,
   output logic               busy,
   output logic               step_stb,
   output logic               done
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SWEEP = 1'b1;

   logic [0:0]         r_state;
   logic [14:0]        r_inc;
   logic [14:0]        r_start_l;
   logic [14:0]        r_stop_l;
   logic [14:0]        r_step;
   logic [14:0]        r_target;
   logic [DWELL_W-1:0] r_dwell;
   logic [DWELL_W-1:0] r_cnt;
   logic               r_mode;
   logic               r_up;
   logic               r_stb;
   logic               r_done;

   logic [14:0]        w_step_eff;
   logic [DWELL_W-1:0] w_dwell_eff;
   logic               w_at_tgt;
   logic               w_boundary;
   logic               w_nxt_up;
   logic [14:0]        w_nxt_tgt;
   logic [15:0]        w_sum;
   logic [15:0]        w_dif;
   logic [14:0]        w_next;

   assign w_step_eff  = (f_step == 15'd0) ? 15'd1 : f_step;
   assign w_dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

   // The counter is loaded with D >= 1, so a count of 1 marks the last cycle of the dwell.
   assign w_at_tgt   = (r_inc == r_target);
   assign w_boundary = (r_cnt == DWELL_W'(1));

   // On reaching an endpoint the direction and target flip before the step is taken.
   assign w_nxt_up  = w_at_tgt ? ~r_up : r_up;
   assign w_nxt_tgt = w_at_tgt ? ((r_target == r_stop_l) ? r_start_l : r_stop_l) : r_target;

   assign w_sum = {1'b0, r_inc} + {1'b0, r_step};
   assign w_dif = {1'b0, r_inc} - {1'b0, r_step};

   always_comb begin
      w_next = w_nxt_tgt;
      if (w_nxt_up) begin
         if (w_sum < {1'b0, w_nxt_tgt}) w_next = w_sum[14:0];
      end else begin
         if (!w_dif[15] && (w_dif[14:0] > w_nxt_tgt)) w_next = w_dif[14:0];
      end
   end

   always_ff @(posedge clk40MHz) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_inc     <= 15'd0;
         r_start_l <= 15'd0;
         r_stop_l  <= 15'd0;
         r_step    <= 15'd1;
         r_target  <= 15'd0;
         r_dwell   <= DWELL_W'(1);
         r_cnt     <= DWELL_W'(1);
         r_mode    <= 1'b0;
         r_up      <= 1'b1;
         r_stb     <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_stb  <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start && !abort) begin
                  r_start_l <= f_start;
                  r_stop_l  <= f_stop;
                  r_step    <= w_step_eff;
                  r_dwell   <= w_dwell_eff;
                  r_mode    <= mode;
                  r_up      <= (f_stop >= f_start);
                  r_target  <= f_stop;
                  r_inc     <= f_start;
                  r_cnt     <= w_dwell_eff;
                  r_stb     <= 1'b1;
                  r_state   <= ST_SWEEP;
               end
            end
            ST_SWEEP: begin
               if (abort) begin
                  r_state <= ST_IDLE;
               end else if (w_boundary) begin
                  if (w_at_tgt && !r_mode) begin
                     r_state <= ST_IDLE;
                     r_done  <= 1'b1;
                  end else begin
                     r_inc    <= w_next;
                     r_up     <= w_nxt_up;
                     r_target <= w_nxt_tgt;
                     r_cnt    <= r_dwell;
                     r_stb    <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - DWELL_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign increment = r_inc;
   assign busy      = (r_state == ST_SWEEP);
   assign step_stb  = r_stb;
   assign done      = r_done;

endmodule

// File: tb/tb_ico_sweep.sv
`timescale 1ns/1ps
// tb_ico_sweep: directed and randomized checks of ico_sweep against a value-list sweep model.
module tb_ico_sweep;

   localparam int DW   = 24;
   localparam int MAXC = 1024;

   logic          clk = 1'b0;
   logic          rst, start, abort, mode;
   logic [14:0]   f_start, f_stop, f_step;
   logic [DW-1:0] dwell;
   logic [14:0]   increment;
   logic          busy, step_stb, done;
   logic [17:0]   got;

   int checks = 0;
   int passes = 0;

   logic [14:0] exp_inc  [MAXC];
   logic        exp_busy [MAXC];
   logic        exp_stb  [MAXC];
   logic        exp_done [MAXC];
   int          n_vals;
   int          eff_d;

   ico_sweep #(.DWELL_W(DW)) dut (
      .clk40MHz (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .f_start  (f_start),
      .f_stop   (f_stop),
      .f_step   (f_step),
      .dwell    (dwell),
      .mode     (mode),
      .increment(increment),
      .busy     (busy),
      .step_stb (step_stb),
      .done     (done)
   );

   always #12.5 clk = ~clk;

   assign got = {increment, busy, step_stb, done};

   // Model: list the values the sweep visits, then expand each into D cycles.
   task automatic build_model(input int fs, input int fe, input int st, input int dw,
                              input int md, input int cyc);
      int vals[$];
      int s, v, tgt, other, tmp, k;
      s     = (st == 0) ? 1 : st;
      eff_d = (dw == 0) ? 1 : dw;
      v     = fs;
      tgt   = fe;
      other = fs;
      vals.push_back(v);
      while (vals.size() < cyc) begin
         if (v == tgt) begin
            if (md == 0) break;
            tmp = tgt; tgt = other; other = tmp;
         end
         if (tgt > v)      v = (tgt - v <= s) ? tgt : v + s;
         else if (tgt < v) v = (v - tgt <= s) ? tgt : v - s;
         vals.push_back(v);
      end
      n_vals = vals.size();
      for (int t = 0; t < cyc; t++) begin
         k = t / eff_d;
         if (k < n_vals) begin
            exp_inc[t]  = vals[k][14:0];
            exp_busy[t] = 1'b1;
            exp_stb[t]  = ((t % eff_d) == 0);
            exp_done[t] = 1'b0;
         end else begin
            exp_inc[t]  = fe[14:0];
            exp_busy[t] = 1'b0;
            exp_stb[t]  = 1'b0;
            exp_done[t] = (t == n_vals * eff_d);
         end
      end
   endtask

   function automatic logic [17:0] want_at(input int t);
      return {exp_inc[t], exp_busy[t], exp_stb[t], exp_done[t]};
   endfunction

   // Present a configuration with start; returns in cycle T+1.
   task automatic kick(input int fs, input int fe, input int st, input int dw, input int md);
      f_start = fs[14:0];
      f_stop  = fe[14:0];
      f_step  = st[14:0];
      dwell   = dw[DW-1:0];
      mode    = md[0];
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
      f_start = 15'd0; f_stop = 15'd0; f_step = 15'd0; dwell = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (got !== 18'd0) $display("FAIL reset got %h want %h", got, 18'd0);
      else passes++;
      rst = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         checks++;
         if (got !== 18'd0) $display("FAIL reset_idle got %h want %h", got, 18'd0);
         else passes++;
      end
   endtask

   task automatic test_single_up;
      kick(13000, 13010, 4, 3, 0);
      build_model(13000, 13010, 4, 3, 0, 16);
      for (int t = 0; t < 16; t++) begin
         if (t > 0) begin @(posedge clk); #1; end
         checks++;
         if (got !== want_at(t)) $display("FAIL single_up t=%0d got %h want %h", t, got, want_at(t));
         else passes++;
      end
   endtask

   task automatic test_down_clamp;
      kick(500, 480, 7, 1, 0);
      build_model(500, 480, 7, 1, 0, 7);
      for (int t = 0; t < 7; t++) begin
         if (t > 0) begin @(posedge clk); #1; end
         checks++;
         if (got !== want_at(t)) $display("FAIL down_clamp t=%0d got %h want %h", t, got, want_at(t));
         else passes++;
      end
   endtask

   task automatic test_continuous_abort;
      logic [17:0] frz;
      kick(100, 104, 2, 2, 1);
      build_model(100, 104, 2, 2, 1, 14);
      for (int t = 0; t < 14; t++) begin
         if (t > 0) begin @(posedge clk); #1; end
         checks++;
         if (got !== want_at(t)) $display("FAIL continuous t=%0d got %h want %h", t, got, want_at(t));
         else passes++;
      end
      // Abort lands on a dwell boundary: the value must freeze with no strobe.
      frz = {exp_inc[13], 3'b000};
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      for (int t = 0; t < 3; t++) begin
         checks++;
         if (got !== frz) $display("FAIL abort_freeze t=%0d got %h want %h", t, got, frz);
         else passes++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_guards;
      kick(32760, 32767, 100, 0, 0);
      build_model(32760, 32767, 100, 0, 0, 5);
      for (int t = 0; t < 5; t++) begin
         if (t > 0) begin @(posedge clk); #1; end
         checks++;
         if (got !== want_at(t)) $display("FAIL overflow t=%0d got %h want %h", t, got, want_at(t));
         else passes++;
      end
      @(posedge clk); #1;
      kick(10, 13, 0, 2, 0);
      build_model(10, 13, 0, 2, 0, 10);
      for (int t = 0; t < 10; t++) begin
         if (t > 0) begin @(posedge clk); #1; end
         checks++;
         if (got !== want_at(t)) $display("FAIL step_zero t=%0d got %h want %h", t, got, want_at(t));
         else passes++;
      end
   endtask

   task automatic test_controls;
      logic [17:0] hold;
      kick(2000, 1990, 3, 2, 0);
      build_model(2000, 1990, 3, 2, 0, 13);
      for (int t = 0; t < 13; t++) begin
         if (t > 0) begin @(posedge clk); #1; end
         checks++;
         if (got !== want_at(t)) $display("FAIL ignore_inputs t=%0d got %h want %h", t, got, want_at(t));
         else passes++;
         f_start = 15'($urandom);
         f_stop  = 15'($urandom);
         f_step  = 15'($urandom);
         dwell   = DW'($urandom_range(0, 5));
         mode    = 1'($urandom);
         start   = (t >= 2 && t <= 5);
      end
      start = 1'b0;
      hold = {15'd1990, 3'b000};
      kick(700, 800, 1, 1, 0);
      // The kick above carried no abort; repeat it with abort so nothing may start.
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      f_start = 15'd700; f_stop = 15'd800; start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      hold = 18'd0;
      for (int t = 0; t < 3; t++) begin
         checks++;
         if (got !== hold) $display("FAIL start_abort t=%0d got %h want %h", t, got, hold);
         else passes++;
         @(posedge clk); #1;
      end
      kick(5000, 6000, 50, 3, 1);
      build_model(5000, 6000, 50, 3, 1, 5);
      for (int t = 0; t < 5; t++) begin
         if (t > 0) begin @(posedge clk); #1; end
         checks++;
         if (got !== want_at(t)) $display("FAIL pre_reset t=%0d got %h want %h", t, got, want_at(t));
         else passes++;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (got !== 18'd0) $display("FAIL mid_reset got %h want %h", got, 18'd0);
      else passes++;
   endtask

   task automatic test_back_to_back;
      @(posedge clk); #1;
      kick(300, 290, 5, 2, 0);
      build_model(300, 290, 5, 2, 0, 7);
      for (int t = 0; t < 7; t++) begin
         if (t > 0) begin @(posedge clk); #1; end
         checks++;
         if (got !== want_at(t)) $display("FAIL b2b_first t=%0d got %h want %h", t, got, want_at(t));
         else passes++;
      end
      // Still in the done cycle: this start must be accepted.
      kick(7, 3, 1, 1, 0);
      build_model(7, 3, 1, 1, 0, 7);
      for (int t = 0; t < 7; t++) begin
         if (t > 0) begin @(posedge clk); #1; end
         checks++;
         if (got !== want_at(t)) $display("FAIL b2b_second t=%0d got %h want %h", t, got, want_at(t));
         else passes++;
      end
   endtask

   task automatic test_random;
      int fs, fe, st, dw, md, cyc;
      logic [17:0] frz;
      for (int r = 0; r < 8; r++) begin
         fs = (r == 0) ? 32700 : ((r == 1) ? 40 : int'($urandom_range(0, 32767)));
         fe = fs + int'($urandom_range(0, 240)) - 120;
         if (fe < 0) fe = 0;
         if (fe > 32767) fe = 32767;
         st = int'($urandom_range(0, 40));
         dw = int'($urandom_range(0, 3));
         md = int'($urandom_range(0, 1));
         kick(fs, fe, st, dw, md);
         if (md == 0) begin
            build_model(fs, fe, st, dw, md, MAXC);
            cyc = n_vals * eff_d + 3;
         end else begin
            cyc = 60;
         end
         build_model(fs, fe, st, dw, md, cyc);
         for (int t = 0; t < cyc; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            checks++;
            if (got !== want_at(t))
               $display("FAIL random r=%0d t=%0d got %h want %h", r, t, got, want_at(t));
            else passes++;
         end
         if (md == 1) begin
            frz = {exp_inc[cyc-1], 3'b000};
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            checks++;
            if (got !== frz) $display("FAIL random_abort r=%0d got %h want %h", r, got, frz);
            else passes++;
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_single_up();
      test_down_clamp();
      test_continuous_abort();
      test_guards();
      test_controls();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
